alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 43 ++++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter:
//   - ALU opcode constants (OP_SLL .. OP_SLTU, 4'b0000 .. 4'b1100)
//   - arbiter FSM state encoding
//   - default EXEC length for multiply/divide
//   - small opcode classification helpers
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0001;
    localparam logic [3:0] OP_SRA  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;

    localparam int MULDIV_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Multi-cycle operations: multiply and divide/remainder.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Opcodes above SLTU have no ALU meaning.
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_SLTU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic (purely combinational).
//   req[1:0]   in   request lines
//   last       in   index of the requester granted most recently
//   grant[1:0] out  one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // Under contention the requester that was not served last wins.
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters. One operation is in
// flight at a time: IDLE (arbitrate/accept) -> EXEC (drive ALU) ->
// RESP (hold result until the consumer takes it).
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid/ready          requester N handshake (ready only in IDLE)
//   reqN_op/x/y               requester N opcode and operands
//   rsp_valid/ready           response handshake
//   rsp_id                    requester that issued the response
//   rsp_r/r2/of/cf/eq         captured ALU results and flags
//   rsp_err                   illegal opcode (results forced to zero)
//   alu_op/x/y                registered operation to the ALU
//   alu_r/r2/of/cf/eq         ALU results, sampled on the last EXEC cycle
// Parameter MULDIV_CYCLES (1..15): EXEC length for multiply/divide.
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_r,
    output logic [31:0] rsp_r2,
    output logic        rsp_of,
    output logic        rsp_cf,
    output logic        rsp_eq,
    output logic        rsp_err,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_r,
    input  logic [31:0] alu_r2,
    input  logic        alu_of,
    input  logic        alu_cf,
    input  logic        alu_eq
);

    // Counter value that marks the last EXEC cycle of a multi-cycle op.
    localparam logic [3:0] MD_LAST = 4'(MULDIV_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic        last_reg;
    logic [3:0]  cnt_reg;
    logic [1:0]  grant;
    logic [3:0]  sel_op;
    logic [31:0] sel_x;
    logic [31:0] sel_y;

    rr_arb2 u_rr (
        .req   ({req1_valid, req0_valid}),
        .last  (last_reg),
        .grant (grant)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_op = req0_op;
        sel_x  = req0_x;
        sel_y  = req0_y;
        if (grant[1]) begin
            sel_op = req1_op;
            sel_x  = req1_x;
            sel_y  = req1_y;
        end
    end

    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (|grant) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_reg == 4'd0) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // alu_op/x/y are the operation registers themselves: they load only on
    // a grant, so they stay stable through EXEC and hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= 4'd0;
            alu_op    <= 4'b0000;
            alu_x     <= 32'd0;
            alu_y     <= 32'd0;
            rsp_id    <= 1'b0;
            rsp_r     <= 32'd0;
            rsp_r2    <= 32'd0;
            rsp_of    <= 1'b0;
            rsp_cf    <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        alu_op  <= sel_op;
                        alu_x   <= sel_x;
                        alu_y   <= sel_y;
                        rsp_id  <= grant[1];
                        cnt_reg <= is_muldiv(sel_op) ? MD_LAST : 4'd0;
                    end
                end
                ST_EXEC: begin
                    if (cnt_reg == 4'd0) begin
                        if (is_illegal(alu_op)) begin
                            rsp_r   <= 32'd0;
                            rsp_r2  <= 32'd0;
                            rsp_of  <= 1'b0;
                            rsp_cf  <= 1'b0;
                            rsp_eq  <= 1'b0;
                            rsp_err <= 1'b1;
                        end else begin
                            rsp_r   <= alu_r;
                            rsp_r2  <= alu_r2;
                            rsp_of  <= alu_of;
                            rsp_cf  <= alu_cf;
                            rsp_eq  <= alu_eq;
                            rsp_err <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Fairness history advances only once the result is taken.
                    if (rsp_ready) last_reg <= rsp_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed scoreboard bench for alu_arbiter. An accept watcher pushes the
// expected response (prepared by the stimulus) when a requester handshake
// is seen; a response monitor pops and compares when rsp_valid/rsp_ready
// complete, including accept-to-valid latency.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_r, rsp_r2;
    logic        rsp_of, rsp_cf, rsp_eq, rsp_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_r, alu_r2;
    logic        alu_of, alu_cf, alu_eq;

    always #5 clk = ~clk;

    alu_arbiter #(.MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_r2(rsp_r2), .rsp_of(rsp_of), .rsp_cf(rsp_cf),
        .rsp_eq(rsp_eq), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
        .alu_r(alu_r), .alu_r2(alu_r2), .alu_of(alu_of), .alu_cf(alu_cf),
        .alu_eq(alu_eq)
    );

    // Behavioural ALU attached to the arbiter.
    logic [63:0] prod;
    logic [32:0] sum;
    always_comb begin
        alu_r  = 32'd0;
        alu_r2 = 32'd0;
        alu_of = 1'b0;
        alu_cf = 1'b0;
        alu_eq = (alu_x == alu_y);
        prod   = 64'd0;
        sum    = 33'd0;
        case (alu_op)
            OP_SLL:  alu_r = alu_x << alu_y[4:0];
            OP_SRL:  alu_r = alu_x >> alu_y[4:0];
            OP_SRA:  alu_r = $signed(alu_x) >>> alu_y[4:0];
            OP_MUL: begin
                prod   = $signed({{32{alu_x[31]}}, alu_x}) * $signed({{32{alu_y[31]}}, alu_y});
                alu_r  = prod[31:0];
                alu_r2 = prod[63:32];
            end
            OP_DIV: begin
                if (alu_y != 32'd0) begin
                    alu_r  = $signed(alu_x) / $signed(alu_y);
                    alu_r2 = $signed(alu_x) % $signed(alu_y);
                end else begin
                    alu_r  = 32'hFFFF_FFFF;
                    alu_r2 = alu_x;
                end
            end
            OP_ADD: begin
                sum    = {1'b0, alu_x} + {1'b0, alu_y};
                alu_r  = sum[31:0];
                alu_cf = sum[32];
                alu_of = (alu_x[31] == alu_y[31]) && (sum[31] != alu_x[31]);
            end
            OP_SUB: begin
                sum    = {1'b0, alu_x} + {1'b0, ~alu_y} + 33'd1;
                alu_r  = sum[31:0];
                alu_cf = sum[32];
                alu_of = (alu_x[31] != alu_y[31]) && (sum[31] != alu_x[31]);
            end
            OP_AND:  alu_r = alu_x & alu_y;
            OP_OR:   alu_r = alu_x | alu_y;
            OP_XOR:  alu_r = alu_x ^ alu_y;
            OP_NOR:  alu_r = ~(alu_x | alu_y);
            OP_SLT:  alu_r = {31'd0, $signed(alu_x) < $signed(alu_y)};
            OP_SLTU: alu_r = {31'd0, alu_x < alu_y};
            default: begin
                // Garbage on illegal opcodes so masking is observable.
                alu_r  = alu_x ^ 32'hDEAD_BEEF;
                alu_r2 = 32'hBAD0_BAD0;
                alu_of = 1'b1;
                alu_cf = 1'b1;
            end
        endcase
    end

    typedef struct {
        logic        id;
        logic [31:0] r;
        logic [31:0] r2;
        logic        of;
        logic        cf;
        logic        eq;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp0, exp1;
    int   acc_log[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Accept watcher: a requester handshake pushes its prepared expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (req0_ready) begin
                e = exp0; e.id = 1'b0; e.acc = cyc;
                sb_q.push_back(e); acc_log.push_back(0);
                $display("ACCEPT req0 op=%b x=%08h y=%08h cyc=%0d", req0_op, req0_x, req0_y, cyc);
            end
            if (req1_ready) begin
                e = exp1; e.id = 1'b1; e.acc = cyc;
                sb_q.push_back(e); acc_log.push_back(1);
                $display("ACCEPT req1 op=%b x=%08h y=%08h cyc=%0d", req1_op, req1_x, req1_y, cyc);
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=valid id=%0d r=%08h required=no_response", rsp_id, rsp_r);
            end else begin
                e = sb_q[0];
                if (!seen) begin
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    seen = 1'b1;
                end
                if (rsp_ready) begin
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_r", 64'(rsp_r), 64'(e.r));
                    chk("rsp_r2", 64'(rsp_r2), 64'(e.r2));
                    chk("rsp_flags_of_cf_eq", 64'({rsp_of, rsp_cf, rsp_eq}), 64'({e.of, e.cf, e.eq}));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    $display("RSP id=%0d r=%08h r2=%08h of=%0d cf=%0d eq=%0d err=%0d cyc=%0d",
                             rsp_id, rsp_r, rsp_r2, rsp_of, rsp_cf, rsp_eq, rsp_err, cyc);
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic set_exp(input int who, input logic [31:0] r, input logic [31:0] r2,
                           input logic of, input logic cf, input logic eq,
                           input logic err, input int lat);
        exp_t e;
        e.id = who[0]; e.r = r; e.r2 = r2; e.of = of; e.cf = cf; e.eq = eq;
        e.err = err; e.lat = lat; e.acc = 0;
        if (who == 0) exp0 = e; else exp1 = e;
    endtask

    task automatic drive(input int who, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        if (who == 0) begin
            req0_op = op; req0_x = x; req0_y = y; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_x = x; req1_y = y; req1_valid = 1'b1;
        end
    endtask

    // Wait (bounded) for requester who to be accepted, then drop its valid.
    task automatic wait_accept(input int who);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout req%0d actual=no_ready required=ready", who);
        end
        @(posedge clk); #1;
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_accepts(input int n);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (acc_log.size() >= n) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_count actual=%0d required=%0d", acc_log.size(), n);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 4'd0; req0_x = 32'd0; req0_y = 32'd0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_x = 32'd0; req1_y = 32'd0;
        rsp_ready = 1'b1;
        #3;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_readies", 64'({req1_ready, req0_ready}), 64'd0);
        chk("reset_alu_op", 64'(alu_op), 64'd0);
        chk("reset_alu_xy", {alu_x, alu_y}, 64'd0);
        chk("reset_rsp_r_r2", {rsp_r, rsp_r2}, 64'd0);
        chk("reset_rsp_bits", 64'({rsp_id, rsp_of, rsp_cf, rsp_eq, rsp_err}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Contention from reset: alternate 0,1,0,1 with both held valid.
        acc_log.delete();
        set_exp(0, 32'h00F0_000F, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        set_exp(1, 32'h1200_5634, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        drive(0, OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        drive(1, OP_OR,  32'h1200_0034, 32'h0000_5600);
        wait_accepts(4);
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("grant_order%0d", i), 64'(acc_log[i]), 64'(i % 2));
        end
        drain();

        // Single add.
        set_exp(0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        drive(0, OP_ADD, 32'd7, 32'd5);
        wait_accept(0);
        drain();

        // Add flag corners: signed overflow, carry-out, equal operands.
        set_exp(1, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        drive(1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        wait_accept(1);
        drain();
        set_exp(0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        drive(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        wait_accept(0);
        drain();
        set_exp(1, 32'd18, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        drive(1, OP_ADD, 32'd9, 32'd9);
        wait_accept(1);
        drain();

        // Multiply: 4 EXEC cycles with stable ALU inputs, valid 5 after accept.
        set_exp(1, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        drive(1, OP_MUL, 32'hFFFF_FFFD, 32'd2);
        wait_accept(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mul_exec%0d_alu_xy", i), {alu_x, alu_y}, {32'hFFFF_FFFD, 32'd2});
            chk($sformatf("mul_exec%0d_alu_op", i), 64'(alu_op), 64'(OP_MUL));
        end
        drain();

        // Divide: -7 / 2 = -3 remainder -1.
        set_exp(0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        drive(0, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_accept(0);
        drain();

        // Illegal opcode under backpressure.
        rsp_ready = 1'b0;
        set_exp(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        drive(0, 4'b1110, 32'd5, 32'd5);
        wait_accept(0);
        set_exp(1, 32'h0000_00F0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        drive(1, OP_XOR, 32'h0000_00FF, 32'h0000_000F);
        @(negedge clk);
        chk("exec_req1_ready", 64'(req1_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid_err", i), 64'({rsp_valid, rsp_err}), 64'b11);
            chk($sformatf("bp%0d_r_r2", i), {rsp_r, rsp_r2}, 64'd0);
            chk($sformatf("bp%0d_readies", i), 64'({req1_ready, req0_ready}), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_take_req1_ready", 64'(req1_ready), 64'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // Reset in the second EXEC cycle of a multiply.
        set_exp(1, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        drive(1, OP_MUL, 32'hFFFF_FFFD, 32'd2);
        wait_accept(1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_alu_op_x", {28'd0, alu_op, alu_x}, 64'd0);
        chk("abort_rsp_r", 64'(rsp_r), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post_abort%0d_rsp_valid", i), 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        acc_log.delete();
        set_exp(0, 32'h00F0_000F, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        set_exp(1, 32'h1200_5634, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        drive(0, OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        drive(1, OP_OR,  32'h1200_0034, 32'h0000_5600);
        wait_accepts(1);
        if (acc_log.size() >= 1)
            chk("post_reset_first_grant", 64'(acc_log[0]), 64'd0);
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
